// File: rtl/store_data_aligner.sv
// Store aligner: lane-shifts sb/sh/sw data into word writes, splitting boundary-crossing stores in two.
// Latency: accept->mem_req 1 cycle; done 1 cycle after last ack. Backpressure: st_ready low while busy, beats wait on mem_ack.
module store_data_aligner #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_st_valid,
    output logic              o_st_ready,
    input  logic [2:0]        i_st_type,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic [31:0]       i_st_data,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_be,
    input  logic              i_mem_ack,
    output logic              o_st_done,
    output logic              o_st_split
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_st_split;
    logic [31:0]       r_b1_wdata;
    logic [3:0]        r_b1_be;

    logic [1:0]        w_off;
    logic [3:0]        w_base;
    logic [31:0]       w_d;
    logic              w_type_ok;
    logic [7:0]        w_mask8;
    logic [63:0]       w_data64;
    logic [ADDR_W-1:0] w_word_addr;

    always_comb begin
        w_base    = 4'b0000;
        w_d       = 32'h0;
        w_type_ok = 1'b0;
        case (i_st_type)
            3'b001: begin w_base = 4'b0001; w_d = {24'h0, i_st_data[7:0]};  w_type_ok = 1'b1; end
            3'b010: begin w_base = 4'b0011; w_d = {16'h0, i_st_data[15:0]}; w_type_ok = 1'b1; end
            3'b011: begin w_base = 4'b1111; w_d = i_st_data;                w_type_ok = 1'b1; end
            default: ;
        endcase
        w_off       = i_st_addr[1:0];
        w_mask8     = {4'b0000, w_base} << w_off;
        w_data64    = {32'h0, w_d} << {w_off, 3'b000};
        w_word_addr = {i_st_addr[ADDR_W-1:2], 2'b00};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= 4'b0000;
            r_st_split  <= 1'b0;
            r_b1_wdata  <= 32'h0;
            r_b1_be     <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_st_valid) begin
                        if (w_type_ok) begin
                            r_state     <= S_BEAT0;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= w_data64[31:0];
                            r_mem_be    <= w_mask8[3:0];
                            r_st_split  <= |w_mask8[7:4];
                            r_b1_wdata  <= w_data64[63:32];
                            r_b1_be     <= w_mask8[7:4];
                        end else begin
                            // Unknown store type completes without touching memory
                            r_state    <= S_DONE;
                            r_st_split <= 1'b0;
                        end
                    end
                end
                S_BEAT0: begin
                    if (i_mem_ack) begin
                        if (r_st_split) begin
                            r_state     <= S_BEAT1;
                            r_mem_addr  <= r_mem_addr + ADDR_W'(4);
                            r_mem_wdata <= r_b1_wdata;
                            r_mem_be    <= r_b1_be;
                        end else begin
                            r_state   <= S_DONE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                S_BEAT1: begin
                    if (i_mem_ack) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_st_split <= 1'b0;
                end
            endcase
        end
    end

    assign o_st_ready  = (r_state == S_IDLE);
    assign o_st_done   = (r_state == S_DONE);
    assign o_st_split  = r_st_split;
    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_be    = r_mem_be;

endmodule

// File: tb/tb_store_data_aligner.sv
// Bench for store_data_aligner: directed scenarios plus random stores checked against a byte-level model.
module tb_store_data_aligner;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        st_done;
    logic        st_split;

    int n_cmp  = 0;
    int n_fail = 0;

    store_data_aligner #(.ADDR_W(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_st_valid (st_valid),
        .o_st_ready (st_ready),
        .i_st_type  (st_type),
        .i_st_addr  (st_addr),
        .i_st_data  (st_data),
        .o_mem_req  (mem_req),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_be   (mem_be),
        .i_mem_ack  (mem_ack),
        .o_st_done  (st_done),
        .o_st_split (st_split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; st_type = 3'b0; st_addr = 32'h0; st_data = 32'h0; mem_ack = 1'b0;
        step(); step();
        n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", st_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin n_fail++; $display("FAIL reset_bus: got %h/%h/%b want zeros", mem_addr, mem_wdata, mem_be); end
        n_cmp++; if ({st_done, st_split} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got done=%b split=%b want 0/0", st_done, st_split); end
        rst_n = 1'b1;
        step();
    endtask

    // Performs one store and checks every cycle against a byte-by-byte model of where each byte lands.
    task automatic run_store(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] d,
                             input int dly, input string nm);
        logic [31:0] ea [2];
        logic [3:0]  eb [2];
        logic [31:0] ew [2];
        logic [31:0] ba;
        int n, nb, bt, lane;
        n = (ty == 3'd1) ? 1 : (ty == 3'd2) ? 2 : (ty == 3'd3) ? 4 : 0;
        ea[0] = a & 32'hFFFF_FFFC;
        ea[1] = ea[0] + 32'd4;
        for (int b = 0; b < 2; b++) begin eb[b] = 4'b0; ew[b] = 32'h0; end
        for (int k = 0; k < n; k++) begin
            ba   = a + k;
            bt   = ((ba & 32'hFFFF_FFFC) == ea[0]) ? 0 : 1;
            lane = int'(ba[1:0]);
            eb[bt][lane] = 1'b1;
            ew[bt][lane*8 +: 8] = d[8*k +: 8];
        end
        nb = (n == 0) ? 0 : ((eb[1] != 4'b0) ? 2 : 1);

        n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL %s pre_ready: got %b want 1", nm, st_ready); end
        st_valid = 1'b1; st_type = ty; st_addr = a; st_data = d;
        step();
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w <= dly; w++) begin
                st_valid = 1'(($urandom_range(0, 1))); st_type = 3'($urandom); st_addr = $urandom; st_data = $urandom;
                n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL %s b%0d req: got %b want 1", nm, b, mem_req); end
                n_cmp++; if (mem_addr !== ea[b]) begin n_fail++; $display("FAIL %s b%0d addr: got %h want %h", nm, b, mem_addr, ea[b]); end
                n_cmp++; if (mem_be !== eb[b]) begin n_fail++; $display("FAIL %s b%0d be: got %b want %b", nm, b, mem_be, eb[b]); end
                n_cmp++; if (mem_wdata !== ew[b]) begin n_fail++; $display("FAIL %s b%0d wdata: got %h want %h", nm, b, mem_wdata, ew[b]); end
                n_cmp++; if (st_split !== (nb == 2)) begin n_fail++; $display("FAIL %s b%0d split: got %b want %b", nm, b, st_split, nb == 2); end
                n_cmp++; if ((st_done | st_ready) !== 1'b0) begin n_fail++; $display("FAIL %s b%0d busy: got done=%b ready=%b want 0/0", nm, b, st_done, st_ready); end
                mem_ack = (w == dly);
                step();
                mem_ack = 1'b0;
            end
        end
        st_valid = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s end_req: got %b want 0", nm, mem_req); end
        n_cmp++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL %s done_pulse: got %b want 1", nm, st_done); end
        n_cmp++; if (st_split !== (nb == 2)) begin n_fail++; $display("FAIL %s done_split: got %b want %b", nm, st_split, nb == 2); end
        step();
        n_cmp++; if ({st_done, st_ready, st_split} !== 3'b010) begin n_fail++; $display("FAIL %s idle: got done/ready/split=%b%b%b want 010", nm, st_done, st_ready, st_split); end
    endtask

    task automatic test_directed();
        run_store(3'b001, 32'h0000_1002, 32'hAABB_CCDD, 0, "sb_1002");
        run_store(3'b010, 32'h0000_2003, 32'h1234_5678, 0, "sh_2003_split");
        run_store(3'b011, 32'hFFFF_FFFE, 32'hCAFE_BABE, 3, "sw_wrap_wait");
        run_store(3'b100, 32'h0000_0010, 32'h1111_1111, 0, "invalid_type");
        run_store(3'b011, 32'h0000_0080, 32'h0BAD_F00D, 2, "sw_aligned_wait");
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_req, exp_done, exp_rdy, got_req, got_done, got_rdy;
        int pulses;
        exp_req  = 6'b001001;   // bit i = sample after accept edge + i
        exp_done = 6'b010010;
        exp_rdy  = 6'b100100;
        pulses = 0;
        st_valid = 1'b1; st_type = 3'b011; st_addr = 32'h40; st_data = 32'h5566_7788; mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            got_req[i] = mem_req; got_done[i] = st_done; got_rdy[i] = st_ready;
            if (st_done === 1'b1) pulses++;
            if (i == 3) st_valid = 1'b0;
        end
        mem_ack = 1'b0;
        n_cmp++; if (got_req !== exp_req) begin n_fail++; $display("FAIL b2b_req: got %b want %b", got_req, exp_req); end
        n_cmp++; if (got_done !== exp_done) begin n_fail++; $display("FAIL b2b_done: got %b want %b", got_done, exp_done); end
        n_cmp++; if (got_rdy !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready: got %b want %b", got_rdy, exp_rdy); end
        n_cmp++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        step();
    endtask

    task automatic test_reset_mid();
        st_valid = 1'b1; st_type = 3'b011; st_addr = 32'h0000_0105; st_data = 32'hDEAD_BEEF;
        step();
        st_valid = 1'b0; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h108}) begin n_fail++; $display("FAIL rstmid_beat1: got req=%b addr=%h want 1/00000108", mem_req, mem_addr); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if ({mem_req, mem_be, st_ready, st_done} !== 7'b0000010) begin n_fail++; $display("FAIL rstmid_abort: got req=%b be=%b ready=%b done=%b want 0/0000/1/0", mem_req, mem_be, st_ready, st_done); end
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({mem_req, st_done, st_ready} !== 3'b001) begin n_fail++; $display("FAIL rstmid_stray_ack%0d: got req/done/ready=%b%b%b want 001", i, mem_req, st_done, st_ready); end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_store(3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
